// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - shared TAP states, opcodes and TMS transition function
package jtag_pkg;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET,
    RUN_TEST_IDLE,
    SELECT_DR,
    CAPTURE_DR,
    SHIFT_DR,
    EXIT1_DR,
    PAUSE_DR,
    EXIT2_DR,
    UPDATE_DR,
    SELECT_IR,
    CAPTURE_IR,
    SHIFT_IR,
    EXIT1_IR,
    PAUSE_IR,
    EXIT2_IR,
    UPDATE_IR
  } tap_state_t;

  localparam logic [3:0]  OPC_BYPASS     = 4'hF;
  localparam logic [3:0]  OPC_IDCODE     = 4'h1;
  localparam logic [3:0]  OPC_SAMPLE     = 4'h2;
  localparam logic [31:0] DEFAULT_IDCODE = 32'h1234_5001;

  // Standard 1149.1 TMS diagram
  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    tap_state_t n;
    n = TEST_LOGIC_RESET;
    case (s)
      TEST_LOGIC_RESET: n = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    n = tms ? SELECT_DR : RUN_TEST_IDLE;
      SELECT_DR:        n = tms ? SELECT_IR : CAPTURE_DR;
      CAPTURE_DR:       n = tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR:         n = tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR:         n = tms ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:         n = tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR:         n = tms ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR:        n = tms ? SELECT_DR : RUN_TEST_IDLE;
      SELECT_IR:        n = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       n = tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR:         n = tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR:         n = tms ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:         n = tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR:         n = tms ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR:        n = tms ? SELECT_DR : RUN_TEST_IDLE;
      default:          n = TEST_LOGIC_RESET;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// rtl/jtag_tap_fsm.sv - TAP state register with registered state-decode flags
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic tms_i,
  output logic tlr_o,
  output logic capture_dr_o,
  output logic shift_dr_o,
  output logic update_dr_o,
  output logic capture_ir_o,
  output logic shift_ir_o,
  output logic update_ir_o
);

  tap_state_t state_q;
  tap_state_t state_d;

  // Next state from the TMS diagram
  always_comb begin
    state_d = tap_next(state_q, tms_i);
  end

  // State register; flags are decoded from the next state so they are valid
  // in the very cycle the state is entered
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= TEST_LOGIC_RESET;
      tlr_o        <= 1'b1;
      capture_dr_o <= 1'b0;
      shift_dr_o   <= 1'b0;
      update_dr_o  <= 1'b0;
      capture_ir_o <= 1'b0;
      shift_ir_o   <= 1'b0;
      update_ir_o  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tlr_o        <= (state_d == TEST_LOGIC_RESET);
      capture_dr_o <= (state_d == CAPTURE_DR);
      shift_dr_o   <= (state_d == SHIFT_DR);
      update_dr_o  <= (state_d == UPDATE_DR);
      capture_ir_o <= (state_d == CAPTURE_IR);
      shift_ir_o   <= (state_d == SHIFT_IR);
      update_ir_o  <= (state_d == UPDATE_IR);
    end
  end

endmodule

// File: rtl/jtag_tap_controller.sv
// rtl/jtag_tap_controller.sv - TAP top: IR, bypass/IDCODE registers, TDO mux; IDCODE enabled by JTAG_IDCODE_EN
module jtag_tap_controller
  import jtag_pkg::*;
#(
  parameter int          IR_LENGTH    = 4,
  parameter logic [31:0] IDCODE_VALUE = DEFAULT_IDCODE,
  parameter int          DR_LENGTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tms,
  input  logic                 tdi,
  input  logic                 drSerialIn,
  output logic                 tdo,
  output logic                 tdoEn,
  output logic                 drLoad,
  output logic                 drShift,
  output logic                 drUpdate,
  output logic [IR_LENGTH-1:0] irValue
);

  localparam logic [IR_LENGTH-1:0] IR_BYPASS  = '1;
  localparam logic [IR_LENGTH-1:0] IR_SAMPLE  = IR_LENGTH'(OPC_SAMPLE);
  localparam logic [IR_LENGTH-1:0] IR_CAPTURE = IR_LENGTH'(2'b01);
`ifdef JTAG_IDCODE_EN
  localparam logic [IR_LENGTH-1:0] IR_IDCODE  = IR_LENGTH'(OPC_IDCODE);
  localparam logic [IR_LENGTH-1:0] IR_RESET   = IR_IDCODE;
`else
  localparam logic [IR_LENGTH-1:0] IR_RESET   = IR_BYPASS;
`endif

  logic tlr, capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir;

  logic [IR_LENGTH-1:0] ir_shift_q;
  logic [IR_LENGTH-1:0] ir_value_q;
  logic                 bypass_q;
  logic                 sel_sample;
  logic                 sel_idcode;
`ifdef JTAG_IDCODE_EN
  logic [31:0]          idcode_q;
`endif

  jtag_tap_fsm u_fsm (
    .clk_i        (clk),
    .rst_i        (rst),
    .tms_i        (tms),
    .tlr_o        (tlr),
    .capture_dr_o (capture_dr),
    .shift_dr_o   (shift_dr),
    .update_dr_o  (update_dr),
    .capture_ir_o (capture_ir),
    .shift_ir_o   (shift_ir),
    .update_ir_o  (update_ir)
  );

  // The reset instruction is visible as soon as TEST_LOGIC_RESET is entered
  assign irValue = tlr ? IR_RESET : ir_value_q;

  assign sel_sample = (irValue == IR_SAMPLE);
`ifdef JTAG_IDCODE_EN
  assign sel_idcode = (irValue == IR_IDCODE);
`else
  assign sel_idcode = 1'b0;
`endif

  // Instruction shift register and the committed instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_shift_q <= '0;
      ir_value_q <= IR_RESET;
    end else if (tlr) begin
      ir_value_q <= IR_RESET;
    end else if (capture_ir) begin
      ir_shift_q <= IR_CAPTURE;
    end else if (shift_ir) begin
      ir_shift_q <= {tdi, ir_shift_q[IR_LENGTH-1:1]};
    end else if (update_ir) begin
      ir_value_q <= ir_shift_q;
    end
  end

  // Single-bit bypass path, used for every opcode that is not IDCODE or SAMPLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bypass_q <= 1'b0;
    end else if (!sel_sample && !sel_idcode) begin
      if (capture_dr) begin
        bypass_q <= 1'b0;
      end else if (shift_dr) begin
        bypass_q <= tdi;
      end
    end
  end

`ifdef JTAG_IDCODE_EN
  // Device identification register, shifted out LSB first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idcode_q <= '0;
    end else if (sel_idcode) begin
      if (capture_dr) begin
        idcode_q <= IDCODE_VALUE;
      end else if (shift_dr) begin
        idcode_q <= {tdi, idcode_q[31:1]};
      end
    end
  end
`endif

  // TDO mux: LSB of whichever register is currently being shifted
  always_comb begin
    tdo = 1'b0;
    if (shift_ir) begin
      tdo = ir_shift_q[0];
    end else if (shift_dr) begin
      if (sel_sample) begin
        tdo = drSerialIn;
`ifdef JTAG_IDCODE_EN
      end else if (sel_idcode) begin
        tdo = idcode_q[0];
`endif
      end else begin
        tdo = bypass_q;
      end
    end
  end

  assign tdoEn    = shift_dr | shift_ir;
  assign drLoad   = capture_dr & sel_sample;
  assign drShift  = shift_dr & sel_sample;
  assign drUpdate = update_dr & sel_sample;

  // Parameter sanity and mutual exclusion of scan-register strobes
  always @(posedge clk) begin
    if (!rst) begin
      assert (IDCODE_VALUE[0] == 1'b1 && IR_LENGTH >= 2 && DR_LENGTH >= 1);
      assert (!(drLoad && drShift) && !(drShift && drUpdate));
    end
  end

endmodule

// File: tb/tb_jtag_tap_controller.sv
// tb/tb_jtag_tap_controller.sv - scoreboard bench for the TAP controller (honours JTAG_IDCODE_EN)
module tb_jtag_tap_controller;

  localparam logic [31:0] IDCODE = 32'h1234_5001;
`ifdef JTAG_IDCODE_EN
  localparam logic [3:0] RST_IR = 4'h1;
`else
  localparam logic [3:0] RST_IR = 4'hF;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tms = 1'b1;
  logic       tdi = 1'b0;
  logic       dr_serial_in = 1'b0;
  logic       tdo, tdo_en, dr_load, dr_shift, dr_update;
  logic [3:0] ir_value;

  int tests_run = 0;
  int tests_failed = 0;

  typedef enum int {S_TDO, S_TDOEN, S_LOAD, S_SHIFT, S_UPDATE, S_IR} sig_t;
  typedef struct {
    string       tag;
    sig_t        sig;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];

  jtag_tap_controller dut (
    .clk        (clk),
    .rst        (rst),
    .tms        (tms),
    .tdi        (tdi),
    .drSerialIn (dr_serial_in),
    .tdo        (tdo),
    .tdoEn      (tdo_en),
    .drLoad     (dr_load),
    .drShift    (dr_shift),
    .drUpdate   (dr_update),
    .irValue    (ir_value)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_sig(input string tag, input sig_t sig, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    logic [31:0] obs;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.sig)
        S_TDO:    obs = {31'd0, tdo};
        S_TDOEN:  obs = {31'd0, tdo_en};
        S_LOAD:   obs = {31'd0, dr_load};
        S_SHIFT:  obs = {31'd0, dr_shift};
        S_UPDATE: obs = {31'd0, dr_update};
        default:  obs = {28'd0, ir_value};
      endcase
      check(e.tag, obs, e.val);
    end
  endtask

  // Drive TMS/TDI, clock once, settle just after the edge
  task automatic step(input logic t_ms, input logic t_di);
    tms = t_ms;
    tdi = t_di;
    @(posedge clk);
    #1;
  endtask

  // From RUN_TEST_IDLE: shift an opcode into the IR and return to RUN_TEST_IDLE
  task automatic load_ir(input logic [3:0] code);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    expect_sig("ir_tdoen", S_TDOEN, 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i == 0) expect_sig("ir_tdo0", S_TDO, 32'd1);
      if (i == 1) expect_sig("ir_tdo1", S_TDO, 32'd0);
      sb_check();
      step(i == 3, code[i]);
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    expect_sig("ir_loaded", S_IR, {28'd0, code});
    sb_check();
  endtask

  // Bypass-class opcode: tdi 1,0,1,1 must come out as 0,1,0,1
  task automatic bypass_run(input logic [3:0] code, input string tag);
    logic [3:0] din;
    logic [3:0] dout;
    din  = 4'b1101;
    dout = 4'b1010;
    load_ir(code);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      expect_sig(tag, S_TDO, {31'd0, dout[i]});
      sb_check();
      step(i == 3, din[i]);
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] exp_bits;
    logic [31:0] rnd;
    int cnt_en, cnt_load, cnt_shift, cnt_upd;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    expect_sig("rst_tdo", S_TDO, 32'd0);
    expect_sig("rst_tdoen", S_TDOEN, 32'd0);
    expect_sig("rst_ir", S_IR, {28'd0, RST_IR});
    sb_check();
    rst = 1'b0;
    step(1'b1, 1'b0);
    expect_sig("tlr_ir", S_IR, {28'd0, RST_IR});
    expect_sig("tlr_tdo", S_TDO, 32'd0);
    expect_sig("tlr_load", S_LOAD, 32'd0);
    expect_sig("tlr_shift", S_SHIFT, 32'd0);
    expect_sig("tlr_update", S_UPDATE, 32'd0);
    sb_check();

    // Reset-instruction read: IDCODE when present, otherwise the bypass bit
    rnd = $urandom;
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
`ifdef JTAG_IDCODE_EN
    exp_bits = IDCODE;
`else
    exp_bits = {rnd[30:0], 1'b0};
`endif
    cnt_en = 0;
    for (int i = 0; i < 32; i++) begin
      if (tdo_en) cnt_en++;
      expect_sig("id_tdo", S_TDO, {31'd0, exp_bits[i]});
      sb_check();
      step(i == 31, rnd[i]);
    end
    if (tdo_en) cnt_en++;
    check("id_tdoen_cycles", cnt_en, 32);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // SAMPLE: capture strobe, 32 shift cycles, one update pulse
    load_ir(4'h2);
    cnt_load = 0;
    cnt_shift = 0;
    cnt_upd = 0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    expect_sig("smp_load", S_LOAD, 32'd1);
    sb_check();
    if (dr_load) cnt_load++;
    step(1'b0, 1'b0);
    if (dr_load) cnt_load++;
    for (int i = 0; i < 32; i++) begin
      dr_serial_in = 1'($urandom_range(0, 1));
      #1;
      if (dr_shift) cnt_shift++;
      expect_sig("smp_tdo", S_TDO, {31'd0, dr_serial_in});
      sb_check();
      step(i == 31, 1'b0);
    end
    if (dr_shift) cnt_shift++;
    check("smp_load_cycles", cnt_load, 1);
    check("smp_shift_cycles", cnt_shift, 32);
    step(1'b1, 1'b0);
    if (dr_update) cnt_upd++;
    step(1'b0, 1'b0);
    if (dr_update) cnt_upd++;
    check("smp_update_pulses", cnt_upd, 1);

    // BYPASS and an unassigned opcode
    bypass_run(4'hF, "byp_tdo");
    bypass_run(4'h7, "unk_tdo");

    // Five TMS=1 clocks from PAUSE_DR
    load_ir(4'h2);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    repeat (5) step(1'b1, 1'b0);
    expect_sig("tms5_ir", S_IR, {28'd0, RST_IR});
    expect_sig("tms5_load", S_LOAD, 32'd0);
    sb_check();

    // Async reset mid SHIFT_DR under SAMPLE: strobes drop at once
    step(1'b0, 1'b0);
    load_ir(4'h2);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    expect_sig("pre_rst_shift", S_SHIFT, 32'd1);
    sb_check();
    @(negedge clk);
    rst = 1'b1;
    #1;
    expect_sig("rstdr_shift", S_SHIFT, 32'd0);
    expect_sig("rstdr_tdoen", S_TDOEN, 32'd0);
    sb_check();
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0);

    // Async reset mid SHIFT_IR: partial opcode discarded
    load_ir(RST_IR);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    expect_sig("rstir_shift", S_SHIFT, 32'd0);
    expect_sig("rstir_tdoen", S_TDOEN, 32'd0);
    expect_sig("rstir_tdo", S_TDO, 32'd0);
    expect_sig("rstir_ir", S_IR, {28'd0, RST_IR});
    sb_check();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0);
    expect_sig("post_rst_ir", S_IR, {28'd0, RST_IR});
    sb_check();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/jtag_tap_controller.md
# jtag_tap_controller

IEEE 1149.1-style TAP controller driving the SoC scan chain's 32-bit parallel-load shift register. It sits directly upstream of that register:
- Decodes TMS into the 16-state TAP machine.
- Holds the instruction register.
- Issues capture and shift strobes to the scan register.
- Muxes its serial output, a bypass bit, or an internal IDCODE onto TDO.

## Interface
Parameters:
- IR_LENGTH, 4, instruction register width (≥2)
- IDCODE_VALUE, 32'h1234_5001, device ID; bit 0 must be 1
- DR_LENGTH, 32, length of the external scan register; informational, used only by assertions

Ports:
- clk  input  1  TCK; all state changes on the rising edge
- rst  input  1  asynchronous, active-high reset (TRST-equivalent)
- tms  input  1  test mode select, sampled on the rising clk edge
- tdi  input  1  serial data in
- drSerialIn  input  1  serial output (jtagOutput) of the external scan register
- tdo  output  1  serial data out
- tdoEn  output  1  high in SHIFT_DR or SHIFT_IR
- drLoad  output  1  parallel-load strobe to the scan register
- drShift  output  1  shift-enable to the scan register
- drUpdate  output  1  one-cycle pulse in UPDATE_DR when SAMPLE is active
- irValue  output  IR_LENGTH  current (updated) instruction

## Operation
- States are the standard 16 TAP states:
  - TEST_LOGIC_RESET
  - RUN_TEST_IDLE
  - SELECT_DR, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR
  - the same seven for IR
- Transitions follow the 1149.1 TMS diagram exactly.
- From any state, 5 consecutive clocks with tms=1 reach TEST_LOGIC_RESET.
- Instructions at IR_LENGTH=4; any other code decodes as BYPASS:
  - BYPASS = all ones
  - IDCODE = 4'h1
  - SAMPLE = 4'h2
- IR path:
  - CAPTURE_IR loads the IR shift register with ...01 (LSB = 1).
  - SHIFT_IR shifts right, tdi entering the MSB.
  - UPDATE_IR copies the shift register to irValue.
- DR path, selected by irValue:
  - BYPASS: 1-bit register, cleared in CAPTURE_DR, loaded from tdi in SHIFT_DR.
  - IDCODE: 32-bit register, loaded with IDCODE_VALUE in CAPTURE_DR, shifts right in SHIFT_DR.
  - SAMPLE: external register. drLoad=1 while in CAPTURE_DR; drShift=1 while in SHIFT_DR.
- tdo:
  - LSB of the selected register (drSerialIn for SAMPLE) while in SHIFT_DR or SHIFT_IR.
  - 0 otherwise.
- In TEST_LOGIC_RESET, irValue is forced to IDCODE (BYPASS when IDCODE is compiled out).
- PAUSE states hold all register contents; no strobes are asserted.

## Timing
- Reset values:
  - state = TEST_LOGIC_RESET
  - irValue = IDCODE (or BYPASS)
  - tdo = 0, tdoEn = 0
  - drLoad, drShift, drUpdate = 0
  - bypass bit = 0
  - IR and IDCODE shift registers = 0
- drLoad, drShift, drUpdate and tdoEn are Moore outputs decoded from the registered state. They go high in the same cycle the state is entered; no extra latency.
- tdo is combinational from the state and the selected register LSB. The bit shifted out on edge N is visible on tdo before edge N.
- Each SHIFT_DR cycle shifts exactly one bit, including the cycle in which tms=1 moves the machine to EXIT1_DR.
- Path lengths:
  - IDCODE fully read after 32 SHIFT_DR cycles.
  - BYPASS delays tdi by exactly 1 cycle.
- An irValue change takes effect on the rising edge leaving UPDATE_IR. DR selection in the following CAPTURE_DR uses the new value.
- Asserting rst mid-shift:
  - immediately returns to TEST_LOGIC_RESET
  - all strobes drop in the same cycle
  - partial shift contents are discarded; irValue is not updated

## Configuration
- JTAG_IDCODE_EN defined:
  - the 32-bit IDCODE register and opcode 4'h1 are present
  - reset instruction = IDCODE
- Not defined:
  - no IDCODE register
  - opcode 4'h1 decodes as BYPASS
  - reset instruction = BYPASS (all ones)

## Structure
- Shared package jtag_pkg holds:
  - the tap_state_t enum (16 states)
  - the opcode constants OPC_BYPASS, OPC_IDCODE, OPC_SAMPLE
  - DEFAULT_IDCODE
- The scan-register side reuses jtag_pkg constants.
- One sub-module: jtag_tap_fsm, containing the state register, next-state logic and state decode outputs.
- The top level holds:
  - the IR
  - the bypass and IDCODE registers
  - the TDO mux

## Test plan
- **Reset:** rst=1 for 2 cycles, then 0 with tms=1 → state TEST_LOGIC_RESET, irValue=4'h1, tdo=0, all strobes 0.
- **IDCODE read:**
  - tms sequence 0,1,0,0 → in SHIFT_DR.
  - 32 shifts (tms=1 on the last) → tdo yields 32'h1234_5001 LSB first.
  - tdoEn is high for exactly 32 cycles.
- **Load SAMPLE:**
  - shift 4'h2 through SHIFT_IR, then UPDATE_IR → irValue=4'h2.
  - IR tdo during the shift begins 1,0.
- **SAMPLE capture/shift:**
  - CAPTURE_DR → drLoad high exactly 1 cycle.
  - 32 SHIFT_DR cycles → drShift high 32 cycles; tdo mirrors drSerialIn each cycle.
  - UPDATE_DR → drUpdate pulses once.
- **BYPASS:**
  - load IR 4'hF, capture, shift tdi=1,0,1,1 → tdo=0,1,0,1.
  - unknown opcode 4'h7 behaves identically.
- **Reset recovery:**
  - 5 tms=1 clocks from PAUSE_DR → TEST_LOGIC_RESET, irValue=4'h1.
  - rst asserted mid SHIFT_IR → drShift, tdoEn and tdo drop to 0 immediately; irValue unchanged.
